// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux_gate.
// Registered one-hot grant, mux select, busy and switch pulse.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       switch_p
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_grant;
  logic [1:0]       r_select;
  logic             r_busy;
  logic             r_switch;

  logic [1:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_grant_nxt;
  logic [1:0]       w_select_nxt;
  logic             w_switch_nxt;

  logic [3:0]       w_others;
  logic             w_any_oth;
  logic             w_own_req;
  logic [1:0]       w_win_all;
  logic [1:0]       w_win_oth;
  logic             w_at_max;

  // First set bit of r scanning p+1, p+2, p+3, p (mod 4)
  function automatic logic [1:0] f_pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] idx;
    logic       found;
    f_pick = p;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        f_pick = idx;
        found  = 1'b1;
      end
    end
  endfunction

  // Owner is the current select; the rest are contenders
  always_comb begin
    w_others  = req & ~(4'b0001 << r_select);
    w_any_oth = |w_others;
    w_own_req = req[r_select];
    w_win_all = f_pick(req, r_ptr);
    w_win_oth = f_pick(w_others, r_ptr);
    w_at_max  = (r_cnt == HOLD_MAX);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: leave GRANT only when nobody is requesting
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (|req) w_state_nxt = S_GRANT;
      S_GRANT:
        if (!w_own_req && !w_any_oth) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next grant, select, pointer, hold count, pulse
  always_comb begin
    w_grant_nxt  = r_grant;
    w_select_nxt = r_select;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_switch_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_grant_nxt = 4'b0000;
        if (|req) begin
          w_grant_nxt  = 4'b0001 << w_win_all;
          w_select_nxt = w_win_all;
          w_ptr_nxt    = w_win_all;
          w_cnt_nxt    = '0;
          w_switch_nxt = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_any_oth && (!w_own_req || w_at_max)) begin
          w_grant_nxt  = 4'b0001 << w_win_oth;
          w_select_nxt = w_win_oth;
          w_ptr_nxt    = w_win_oth;
          w_cnt_nxt    = '0;
          w_switch_nxt = 1'b1;
        end else if (!w_own_req) begin
          w_grant_nxt = 4'b0000;
          w_cnt_nxt   = '0;
        end else if (!w_at_max) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_grant_nxt = 4'b0000;
    endcase
  end

  // Registered outputs and arbitration bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant  <= 4'b0000;
      r_select <= 2'b00;
      r_busy   <= 1'b0;
      r_switch <= 1'b0;
      r_ptr    <= 2'd3;
      r_cnt    <= '0;
    end else begin
      r_grant  <= w_grant_nxt;
      r_select <= w_select_nxt;
      r_busy   <= |w_grant_nxt;
      r_switch <= w_switch_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign grant    = r_grant;
  assign select   = r_select;
  assign busy     = r_busy;
  assign switch_p = r_switch;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: reference model feeds a
// scoreboard queue, plus directed checks on key scenarios.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       switch_p;

  logic [3:0] d_in = 4'b1010;
  logic       mux_out;
  assign mux_out = d_in[select];

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       p;
  } exp_t;

  exp_t sb_q[$];

  int m_own;
  int m_ptr;
  int m_cnt;
  int m_sel;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .grant(grant),
    .select(select),
    .busy(busy),
    .switch_p(switch_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int start);
    for (int k = 1; k <= 4; k++) begin
      if (m[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_own = -1;
    m_ptr = 3;
    m_cnt = 0;
    m_sel = 0;
  endfunction

  task automatic model_step(input logic [3:0] r);
    exp_t e;
    int   w;
    logic sw;
    logic [3:0] oth;
    sw = 1'b0;
    if (m_own < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_own = w; m_ptr = w; m_sel = w; m_cnt = 0; sw = 1'b1;
      end
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      if (oth != 0 && (!r[m_own] || m_cnt == MAX_HOLD - 1)) begin
        w = pick(oth, m_ptr);
        m_own = w; m_ptr = w; m_sel = w; m_cnt = 0; sw = 1'b1;
      end else if (!r[m_own]) begin
        m_own = -1; m_cnt = 0;
      end else if (m_cnt < MAX_HOLD - 1) begin
        m_cnt++;
      end
    end
    e.g = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
    e.s = 2'(m_sel);
    e.b = (m_own >= 0);
    e.p = sw;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL sb_empty got=0 exp=1");
    end else begin
      e = sb_q.pop_front();
      chk("grant", 8'(grant), 8'(e.g));
      chk("select", 8'(select), 8'(e.s));
      chk("busy", 8'(busy), 8'(e.b));
      chk("switch_p", 8'(switch_p), 8'(e.p));
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    chk("rst_grant", 8'(grant), 8'h0);
    chk("rst_select", 8'(select), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_switch", 8'(switch_p), 8'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int sw_cnt;
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    #12;
    rst = 1'b0;
    #2;
    chk("init_grant", 8'(grant), 8'h0);

    // single requester, then held alone
    step(4'b0100);
    chk("single_grant", 8'(grant), 8'h4);
    chk("single_sel", 8'(select), 8'h2);
    chk("single_pulse", 8'(switch_p), 8'h1);
    sw_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0100);
      if (switch_p) sw_cnt++;
    end
    chk("alone_no_switch", 8'(sw_cnt), 8'h0);

    // async reset mid-grant
    do_reset();

    // full round robin, 8 cycles per tenure
    step(4'b1111);
    chk("rr_first", 8'(grant), 8'h1);
    for (int i = 0; i < 7; i++) step(4'b1111);
    chk("rr_hold0", 8'(grant), 8'h1);
    step(4'b1111);
    chk("rr_to1", 8'(grant), 8'h2);
    for (int i = 0; i < 7; i++) step(4'b1111);
    step(4'b1111);
    chk("rr_to2", 8'(grant), 8'h4);
    for (int i = 0; i < 8; i++) step(4'b1111);
    chk("rr_to3", 8'(grant), 8'h8);
    for (int i = 0; i < 8; i++) step(4'b1111);
    chk("rr_wrap0", 8'(grant), 8'h1);

    // release hand-off, no idle gap
    do_reset();
    step(4'b0010);
    step(4'b1010);
    step(4'b1000);
    chk("handoff_grant", 8'(grant), 8'h8);
    chk("handoff_sel", 8'(select), 8'h3);
    chk("handoff_busy", 8'(busy), 8'h1);

    // wrap-around from last owner 3
    do_reset();
    step(4'b1000);
    step(4'b0000);
    chk("idle_sel_hold", 8'(select), 8'h3);
    chk("idle_grant", 8'(grant), 8'h0);
    step(4'b1001);
    chk("wrap_grant", 8'(grant), 8'h1);
    chk("wrap_sel", 8'(select), 8'h0);

    // saturated hold rotates as soon as a contender appears
    do_reset();
    for (int i = 0; i < 12; i++) step(4'b0001);
    step(4'b0011);
    chk("sat_rotate", 8'(grant), 8'h2);

    // mux path
    do_reset();
    step(4'b0001);
    chk("mux0", 8'(mux_out), 8'h0);
    step(4'b0010);
    chk("mux1", 8'(mux_out), 8'h1);
    step(4'b0100);
    chk("mux2", 8'(mux_out), 8'h0);
    step(4'b1000);
    chk("mux3", 8'(mux_out), 8'h1);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)));
      chk("inv_onehot", 8'($onehot0(grant)), 8'h1);
      if (busy) chk("inv_sel", 8'(grant[select]), 8'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
